// File: rtl/dec_16_1.sv
// 4-to-16 one-hot decoder: sixteen combinational strobes gated by reset,
// plus a clock-aligned registered copy for synchronous consumers.
module dec_16_1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  s,
  output logic        S0,
  output logic        S1,
  output logic        S2,
  output logic        S3,
  output logic        S4,
  output logic        S5,
  output logic        S6,
  output logic        S7,
  output logic        S8,
  output logic        S9,
  output logic        S10,
  output logic        S11,
  output logic        S12,
  output logic        S13,
  output logic        S14,
  output logic        S15,
  output logic [15:0] S_q
);

  logic [15:0] strobe_d;

  // Reset gates the combinational strobes too, so nothing downstream fires
  // while the control path is held in reset.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign strobe_d[gi] = rst_n & (s == 4'(gi));
    end
  endgenerate

  assign {S15, S14, S13, S12, S11, S10, S9, S8,
          S7,  S6,  S5,  S4,  S3,  S2,  S1, S0} = strobe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q <= 16'h0000;
    end else begin
      S_q <= strobe_d;
    end
  end

endmodule

// File: tb/tb_dec_16_1.sv
// Self-checking bench for dec_16_1: table sweep, reset and latency
// sequences, and a randomized one-hot run against a shift-based model.
`timescale 1ps/1ps
module tb_dec_16_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s;
  logic        S0, S1, S2, S3, S4, S5, S6, S7;
  logic        S8, S9, S10, S11, S12, S13, S14, S15;
  logic [15:0] S_q;
  logic [15:0] strobes;

  int checks = 0;
  int errors = 0;

  dec_16_1 dut (
    .clk(clk), .rst_n(rst_n), .s(s),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7),
    .S8(S8), .S9(S9), .S10(S10), .S11(S11), .S12(S12), .S13(S13),
    .S14(S14), .S15(S15), .S_q(S_q)
  );

  assign strobes = {S15, S14, S13, S12, S11, S10, S9, S8,
                    S7, S6, S5, S4, S3, S2, S1, S0};

  always #5 clk = ~clk;

  // Reference: the strobe for code k is simply bit k of a one-hot word.
  function automatic logic [15:0] ref_decode(input logic r, input logic [3:0] code);
    return r ? (16'h0001 << code) : 16'h0000;
  endfunction

  logic [15:0] exp_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 16'h0000;
    else        exp_q <= ref_decode(rst_n, s);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  code;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, 4'(i), ref_decode(1'b1, 4'(i))};
    vecs[16] = '{1'b0, 4'd5,     16'h0000};
    vecs[17] = '{1'b0, 4'd15,    16'h0000};
    vecs[18] = '{1'b1, 4'b1010,  16'h0400};
    vecs[19] = '{1'b1, 4'd0,     16'h0001};

    // Reset gating
    rst_n = 1'b0;
    s     = 4'd7;
    #2;
    check("reset_strobes", strobes, 16'h0000);
    check("reset_sq", S_q, 16'h0000);
    @(posedge clk); #1;
    check("reset_sq_after_edge", S_q, 16'h0000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_strobes", strobes, 16'h0080);
    check("release_sq_holds", S_q, 16'h0000);
    @(posedge clk); #1;
    check("release_sq_edge", S_q, 16'h0080);

    // Table sweep
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].r;
      s     = vecs[i].code;
      #1;
      check($sformatf("vec%0d_strobes", i), strobes, vecs[i].exp);
      check($sformatf("vec%0d_sq", i), S_q, exp_q);
    end

    // Registered latency
    @(negedge clk); rst_n = 1'b1; s = 4'd3;
    @(posedge clk); #1;
    check("lat_s3", S_q, 16'h0008);
    @(negedge clk); s = 4'd12;
    @(posedge clk); #1;
    check("lat_s12", S_q, 16'h1000);

    // Mid-operation asynchronous reset pulse
    @(negedge clk); s = 4'd9;
    @(posedge clk); #1;
    check("mid_pre_sq", S_q, 16'h0200);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", strobes, 16'h0000);
    check("mid_rst_sq", S_q, 16'h0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_strobes", strobes, 16'h0200);
    check("mid_rel_sq_holds", S_q, 16'h0000);
    @(posedge clk); #1;
    check("mid_rel_sq_edge", S_q, 16'h0200);

    // Randomized one-hot run
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] prev_exp;
      @(negedge clk);
      prev_exp = ref_decode(rst_n, s);
      check($sformatf("rnd%0d_sq", n), S_q, prev_exp);
      s = 4'($urandom_range(0, 15));
      #1;
      check($sformatf("rnd%0d_onehot", n), 16'($countones(strobes)), 16'd1);
      check($sformatf("rnd%0d_strobes", n), strobes, ref_decode(1'b1, s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
